// File: rtl/ql_dsp_mac_seq.sv
// Sequencer driving one QL_DSP as a multiply-accumulate engine for dot-product jobs.
// Latency: last operand accept to res_valid is DSP_LAT+1 cycles; a zero-length job reaches OUT one cycle after its command.
// Backpressure: op_ready only in RUN and cmd_ready only in IDLE; the result is held until res_ready, and abort overrides every handshake.
module ql_dsp_mac_seq #(
    parameter int LEN_W   = 8,
    parameter int DSP_LAT = 1
) (
    input  logic             clock,
    input  logic             global_resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_unsigned_a,
    input  logic             cmd_unsigned_b,
    input  logic [5:0]       cmd_shift,
    input  logic             cmd_round,
    input  logic             cmd_sat,
    input  logic             cmd_sub,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [19:0]      op_a,
    input  logic [17:0]      op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [37:0]      res_data,
    input  logic             abort,
    output logic             busy,
    output logic             dsp_reset,
    output logic [19:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic             dsp_load_acc,
    output logic [2:0]       dsp_feedback,
    output logic             dsp_unsigned_a,
    output logic             dsp_unsigned_b,
    output logic             dsp_round,
    output logic             dsp_saturate_enable,
    output logic             dsp_subtract,
    output logic [5:0]       dsp_shift_right,
    input  logic [37:0]      dsp_z
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;
    logic [2:0]       drain_q, drain_d;
    logic [37:0]      res_q, res_d;
    logic [19:0]      a_q, a_d;
    logic [17:0]      b_q, b_d;
    logic             load_q, load_d;
    logic             rst_q, rst_d;
    logic             ua_q, ua_d, ub_q, ub_d, rnd_q, rnd_d, sat_q, sat_d, sub_q, sub_d;
    logic [5:0]       shift_q, shift_d;
    logic             abort_eff;

    assign abort_eff = abort && (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        drain_d = drain_q;
        res_d   = res_q;
        a_d     = '0;
        b_d     = '0;
        load_d  = 1'b0;
        rst_d   = 1'b0;
        ua_d    = ua_q;
        ub_d    = ub_q;
        rnd_d   = rnd_q;
        sat_d   = sat_q;
        sub_d   = sub_q;
        shift_d = shift_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    ua_d    = cmd_unsigned_a;
                    ub_d    = cmd_unsigned_b;
                    rnd_d   = cmd_round;
                    sat_d   = cmd_sat;
                    sub_d   = cmd_sub;
                    shift_d = cmd_shift;
                    cnt_d   = cmd_len;
                    if (cmd_len == '0) begin
                        res_d   = '0;
                        state_d = S_OUT;
                    end else begin
                        first_d = 1'b1;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // Idle beats leave a=b=0, load_acc=0: the DSP adds zero.
                if (op_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    load_d  = first_q;
                    first_d = 1'b0;
                    cnt_d   = cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1)) begin
                        drain_d = 3'(DSP_LAT);
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == 3'd0) begin
                    res_d   = dsp_z;
                    state_d = S_OUT;
                end else begin
                    drain_d = drain_q - 3'd1;
                end
            end
            S_OUT: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_eff) begin
            state_d = S_IDLE;
            first_d = 1'b0;
            a_d     = '0;
            b_d     = '0;
            load_d  = 1'b0;
            rst_d   = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge global_resetn) begin
        if (!global_resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            first_q <= 1'b0;
            drain_q <= '0;
            res_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            load_q  <= 1'b0;
            rst_q   <= 1'b1;
            ua_q    <= 1'b0;
            ub_q    <= 1'b0;
            rnd_q   <= 1'b0;
            sat_q   <= 1'b0;
            sub_q   <= 1'b0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            drain_q <= drain_d;
            res_q   <= res_d;
            a_q     <= a_d;
            b_q     <= b_d;
            load_q  <= load_d;
            rst_q   <= rst_d;
            ua_q    <= ua_d;
            ub_q    <= ub_d;
            rnd_q   <= rnd_d;
            sat_q   <= sat_d;
            sub_q   <= sub_d;
            shift_q <= shift_d;
        end
    end

    assign cmd_ready           = (state_q == S_IDLE);
    assign op_ready            = (state_q == S_RUN) && !abort;
    assign res_valid           = (state_q == S_OUT);
    assign res_data            = res_q;
    assign busy                = (state_q != S_IDLE);
    assign dsp_reset           = rst_q;
    assign dsp_a               = a_q;
    assign dsp_b               = b_q;
    assign dsp_load_acc        = load_q;
    assign dsp_feedback        = 3'b000;
    assign dsp_unsigned_a      = ua_q;
    assign dsp_unsigned_b      = ub_q;
    assign dsp_round           = rnd_q;
    assign dsp_saturate_enable = sat_q;
    assign dsp_subtract        = sub_q;
    assign dsp_shift_right     = shift_q;

endmodule

// File: tb/tb_ql_dsp_mac_seq.sv
// Directed bench for ql_dsp_mac_seq with a behavioural signed MAC standing in for QL_DSP.
module tb_ql_dsp_mac_seq;

    localparam int LEN_W = 8;
    localparam int LAT   = 1;

    logic             clock = 1'b0;
    logic             global_resetn;
    logic             cmd_valid, cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_unsigned_a, cmd_unsigned_b, cmd_round, cmd_sat, cmd_sub;
    logic [5:0]       cmd_shift;
    logic             op_valid, op_ready;
    logic [19:0]      op_a;
    logic [17:0]      op_b;
    logic             res_valid, res_ready;
    logic [37:0]      res_data;
    logic             abort, busy;
    logic             dsp_reset;
    logic [19:0]      dsp_a;
    logic [17:0]      dsp_b;
    logic             dsp_load_acc;
    logic [2:0]       dsp_feedback;
    logic             dsp_unsigned_a, dsp_unsigned_b, dsp_round, dsp_saturate_enable, dsp_subtract;
    logic [5:0]       dsp_shift_right;
    logic [37:0]      dsp_z;

    int n_cmp = 0;
    int n_err = 0;

    logic [19:0] va [4];
    logic [17:0] vb [4];
    logic [37:0] exp_res;

    always #5 clock = ~clock;

    ql_dsp_mac_seq #(.LEN_W(LEN_W), .DSP_LAT(LAT)) dut (
        .clock(clock), .global_resetn(global_resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .cmd_unsigned_a(cmd_unsigned_a), .cmd_unsigned_b(cmd_unsigned_b),
        .cmd_shift(cmd_shift), .cmd_round(cmd_round), .cmd_sat(cmd_sat), .cmd_sub(cmd_sub),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .abort(abort), .busy(busy), .dsp_reset(dsp_reset),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_load_acc(dsp_load_acc), .dsp_feedback(dsp_feedback),
        .dsp_unsigned_a(dsp_unsigned_a), .dsp_unsigned_b(dsp_unsigned_b), .dsp_round(dsp_round),
        .dsp_saturate_enable(dsp_saturate_enable), .dsp_subtract(dsp_subtract),
        .dsp_shift_right(dsp_shift_right), .dsp_z(dsp_z)
    );

    // Signed MAC with one register stage, i.e. z follows a/b by one cycle.
    logic signed [37:0] prod;
    logic [37:0]        acc;
    assign prod  = $signed(dsp_a) * $signed(dsp_b);
    assign dsp_z = acc;
    always @(posedge clock or negedge global_resetn) begin
        if (!global_resetn)    acc <= '0;
        else if (dsp_reset)    acc <= '0;
        else if (dsp_load_acc) acc <= prod;
        else                   acc <= acc + prod;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input int len);
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(len);
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic feed(input int len, input int gap);
        for (int i = 0; i < len; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    op_valid = 1'b0;
                    @(negedge clock);
                    chk("bubble_a", 64'(dsp_a), 64'd0);
                    chk("bubble_ld", 64'(dsp_load_acc), 64'd0);
                end
            end
            op_valid = 1'b1;
            op_a     = va[i];
            op_b     = vb[i];
            @(negedge clock);
            op_valid = 1'b0;
            chk("beat_a", 64'(dsp_a), 64'(va[i]));
            chk("beat_b", 64'(dsp_b), 64'(vb[i]));
            chk("beat_ld", 64'(dsp_load_acc), (i == 0) ? 64'd1 : 64'd0);
        end
    endtask

    task automatic wait_res(input int exp_lat);
        int c;
        c = 0;
        while (!res_valid && c < 20) begin
            @(negedge clock);
            c++;
        end
        chk("res_latency", 64'(c), 64'(exp_lat));
    endtask

    task automatic take_res(input logic [37:0] exp);
        chk("res_data", 64'(res_data), 64'(exp));
        res_ready = 1'b1;
        @(negedge clock);
        res_ready = 1'b0;
        chk("res_drop", 64'(res_valid), 64'd0);
        chk("idle_ready", 64'(cmd_ready), 64'd1);
    endtask

    task automatic load_vec3();
        va[0] = 20'd2;  vb[0] = 18'd5;
        va[1] = -20'sd3; vb[1] = 18'd7;
        va[2] = 20'd4;  vb[2] = -18'sd1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int hi;
        global_resetn  = 1'b0;
        cmd_valid      = 1'b0; cmd_len = '0;
        cmd_unsigned_a = 1'b0; cmd_unsigned_b = 1'b0;
        cmd_shift      = 6'd0; cmd_round = 1'b0; cmd_sat = 1'b0; cmd_sub = 1'b0;
        op_valid       = 1'b0; op_a = '0; op_b = '0;
        res_ready      = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_dsp_reset", 64'(dsp_reset), 64'd1);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_dsp_a", 64'(dsp_a), 64'd0);
        global_resetn = 1'b1;
        @(negedge clock);
        chk("dsp_reset_release", 64'(dsp_reset), 64'd0);

        // Back-to-back len=3 job: 2*5 + -3*7 + 4*-1 = -15
        exp_res = -38'sd15;
        load_vec3();
        cmd_shift = 6'd3; cmd_sat = 1'b1;
        send_cmd(3);
        chk("run_busy", 64'(busy), 64'd1);
        chk("run_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("cfg_shift", 64'(dsp_shift_right), 64'd3);
        chk("cfg_sat", 64'(dsp_saturate_enable), 64'd1);
        feed(3, 0);
        wait_res(LAT + 1);
        take_res(exp_res);
        chk("cfg_hold_idle", 64'(dsp_shift_right), 64'd3);

        // Same job with two-cycle gaps between beats
        send_cmd(3);
        feed(3, 2);
        wait_res(LAT + 1);
        take_res(exp_res);

        // Zero-length job goes straight to OUT with no DSP activity
        send_cmd(0);
        chk("len0_valid", 64'(res_valid), 64'd1);
        chk("len0_data", 64'(res_data), 64'd0);
        chk("len0_dsp_a", 64'(dsp_a), 64'd0);
        chk("len0_dsp_ld", 64'(dsp_load_acc), 64'd0);
        take_res(38'd0);

        // Result backpressure while a new command waits
        send_cmd(3);
        feed(3, 0);
        wait_res(LAT + 1);
        va[0] = 20'd3; vb[0] = -18'sd2;
        cmd_valid = 1'b1; cmd_len = LEN_W'(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp_valid", 64'(res_valid), 64'd1);
            chk("bp_data", 64'(res_data), 64'(exp_res));
            chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        res_ready = 1'b1;
        @(negedge clock);
        res_ready = 1'b0;
        chk("bp_drop", 64'(res_valid), 64'd0);
        chk("bp_idle", 64'(busy), 64'd0);
        @(negedge clock);
        cmd_valid = 1'b0;
        chk("bp_accept", 64'(busy), 64'd1);
        feed(1, 0);
        wait_res(LAT + 1);
        take_res(-38'sd6);

        // Abort on the second beat of a len=4 job
        va[0] = 20'd5; vb[0] = 18'd5;
        send_cmd(4);
        feed(1, 0);
        op_valid = 1'b1; op_a = 20'd7; op_b = 18'd7; abort = 1'b1;
        @(negedge clock);
        op_valid = 1'b0; abort = 1'b0;
        chk("abort_dsp_reset", 64'(dsp_reset), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_dsp_a", 64'(dsp_a), 64'd0);
        chk("abort_dsp_ld", 64'(dsp_load_acc), 64'd0);
        chk("abort_res_valid", 64'(res_valid), 64'd0);
        @(negedge clock);
        chk("abort_pulse_end", 64'(dsp_reset), 64'd0);
        hi = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (res_valid) hi++;
        end
        chk("abort_no_result", 64'(hi), 64'd0);

        va[0] = 20'd1; vb[0] = 18'd1;
        send_cmd(1);
        feed(1, 0);
        wait_res(LAT + 1);
        take_res(38'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
